// File: rtl/pulpemu_rst_seq_if.sv
// pulpemu_rst_seq_if
// Groups the reset-sequencer control inputs and the sequenced reset outputs.
//   master : drives the raw reset sources and cause clear; observes the outputs
//   slave  : the sequencer itself
// Signals:
//   pll_locked_i    clock-manager locked (asynchronous)
//   btn_rst_i       push-button reset, active-high, bouncy (asynchronous)
//   ext_rst_n_i     FMC reset pad, active-low (asynchronous)
//   cause_clr_i     synchronous pulse clearing rst_cause_o
//   per_rst_n_o     peripheral-domain reset, active-low
//   soc_rst_n_o     SoC-domain reset, active-low
//   cluster_rst_n_o cluster-domain reset, active-low
//   ready_o         high once every domain is released
//   state_o         current sequencer state
//   rst_cause_o     sticky causes {lock loss, external, button, POR}
interface pulpemu_rst_seq_if;
    logic       pll_locked_i;
    logic       btn_rst_i;
    logic       ext_rst_n_i;
    logic       cause_clr_i;
    logic       per_rst_n_o;
    logic       soc_rst_n_o;
    logic       cluster_rst_n_o;
    logic       ready_o;
    logic [2:0] state_o;
    logic [3:0] rst_cause_o;

    modport master (
        output pll_locked_i, btn_rst_i, ext_rst_n_i, cause_clr_i,
        input  per_rst_n_o, soc_rst_n_o, cluster_rst_n_o, ready_o, state_o, rst_cause_o
    );

    modport slave (
        input  pll_locked_i, btn_rst_i, ext_rst_n_i, cause_clr_i,
        output per_rst_n_o, soc_rst_n_o, cluster_rst_n_o, ready_o, state_o, rst_cause_o
    );
endinterface

// File: rtl/pulpemu_rst_seq.sv
// pulpemu_rst_seq
// Reset sequencer for the FPGA emulation top. Merges clock-manager lock, a
// debounced push-button and the FMC reset pad into one reset request, then
// releases peripheral, SoC and cluster resets in order with fixed gaps.
// Ports:
//   clk_i   free-running clock
//   rstn_i  asynchronous active-low reset
//   bus     pulpemu_rst_seq_if.slave (reset sources in, sequenced resets out)
module pulpemu_rst_seq #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1024,
    parameter int HOLD_CYCLES     = 256,
    parameter int STAGE_GAP       = 16
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    pulpemu_rst_seq_if.slave bus
);

    localparam int MAX_A = (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES : HOLD_CYCLES;
    localparam int MAX_P = (MAX_A > STAGE_GAP) ? MAX_A : STAGE_GAP;
    localparam int CNT_W = $clog2(MAX_P) + 1;

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);

    typedef enum logic [2:0] {
        ST_HOLD      = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_REL_PER   = 3'd2,
        ST_REL_SOC   = 3'd3,
        ST_RUN       = 3'd4
    } state_t;

    // Synchronizer chains, one bit lane per source: {locked, ext_rst_n, btn}.
    logic [SYNC_STAGES-1:0][2:0] sync_reg;
    logic btn_sync, ext_sync, ext_pre, locked_sync;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0],
                         {bus.pll_locked_i, bus.ext_rst_n_i, bus.btn_rst_i}};
        end
    end

    assign btn_sync    = sync_reg[SYNC_STAGES-1][0];
    assign ext_sync    = sync_reg[SYNC_STAGES-1][1];
    assign locked_sync = sync_reg[SYNC_STAGES-1][2];
    assign ext_pre     = sync_reg[SYNC_STAGES-2][1];

    // Debounce: the filtered button only flips after DEBOUNCE_CYCLES
    // consecutive cycles of disagreement with the synced input.
    logic             btn_db_reg, btn_db_next;
    logic [CNT_W-1:0] db_cnt_reg, db_cnt_next;
    logic             db_diff, db_done, btn_rise, ext_fall;

    always_comb begin
        db_diff     = btn_sync ^ btn_db_reg;
        db_done     = db_diff && (db_cnt_reg == DB_LAST);
        db_cnt_next = (db_diff && !db_done) ? db_cnt_reg + 1'b1 : '0;
        btn_db_next = btn_db_reg ^ db_done;
        btn_rise    = db_done && !btn_db_reg;
        // ext_sync falls on the coming edge when the stage before it is already low.
        ext_fall    = ext_sync && !ext_pre;
    end

    // Sequencer FSM.
    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             req, active, lock_loss;

    always_comb begin
        req        = btn_db_reg || !ext_sync;
        active     = (state_reg == ST_REL_PER) || (state_reg == ST_REL_SOC) ||
                     (state_reg == ST_RUN);
        lock_loss  = active && !locked_sync;
        state_next = state_reg;
        cnt_next   = '0;
        case (state_reg)
            ST_HOLD: begin
                if (!req) begin
                    if (cnt_reg == HOLD_LAST) state_next = ST_WAIT_LOCK;
                    else                      cnt_next   = cnt_reg + 1'b1;
                end
            end
            ST_WAIT_LOCK: begin
                if (req)              state_next = ST_HOLD;
                else if (locked_sync) state_next = ST_REL_PER;
            end
            ST_REL_PER, ST_REL_SOC: begin
                if (req || lock_loss) begin
                    state_next = ST_HOLD;
                end else if (cnt_reg == GAP_LAST) begin
                    state_next = (state_reg == ST_REL_PER) ? ST_REL_SOC : ST_RUN;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_RUN: begin
                if (req || lock_loss) state_next = ST_HOLD;
            end
            default: state_next = ST_HOLD;
        endcase
    end

    // Outputs are decoded from the next state so they switch with the state.
    logic       per_reg, soc_reg, cluster_reg, ready_reg;
    logic       per_next, soc_next, cluster_next, ready_next;
    logic [3:0] cause_reg, cause_next;

    always_comb begin
        per_next     = (state_next == ST_REL_PER) || (state_next == ST_REL_SOC) ||
                       (state_next == ST_RUN);
        soc_next     = (state_next == ST_REL_SOC) || (state_next == ST_RUN);
        cluster_next = (state_next == ST_RUN);
        ready_next   = (state_next == ST_RUN);
        // A new cause in the same cycle as a clear survives the clear.
        cause_next   = (bus.cause_clr_i ? 4'b0000 : cause_reg) |
                       {lock_loss, ext_fall, btn_rise, 1'b0};
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            btn_db_reg  <= 1'b0;
            db_cnt_reg  <= '0;
            state_reg   <= ST_HOLD;
            cnt_reg     <= '0;
            per_reg     <= 1'b0;
            soc_reg     <= 1'b0;
            cluster_reg <= 1'b0;
            ready_reg   <= 1'b0;
            cause_reg   <= 4'b0001;
        end else begin
            btn_db_reg  <= btn_db_next;
            db_cnt_reg  <= db_cnt_next;
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            per_reg     <= per_next;
            soc_reg     <= soc_next;
            cluster_reg <= cluster_next;
            ready_reg   <= ready_next;
            cause_reg   <= cause_next;
        end
    end

    assign bus.per_rst_n_o     = per_reg;
    assign bus.soc_rst_n_o     = soc_reg;
    assign bus.cluster_rst_n_o = cluster_reg;
    assign bus.ready_o         = ready_reg;
    assign bus.state_o         = state_reg;
    assign bus.rst_cause_o     = cause_reg;

endmodule
